// File: rtl/mux_scan_seq_pkg.sv
// Shared widths and state encoding for the 16:1 mux scan sequencer.
package mux_scan_seq_pkg;

  localparam int unsigned NCH   = 16;  // channels per frame
  localparam int unsigned SEL_W = 4;   // mux select / channel index width
  localparam int unsigned CNT_W = 4;   // dwell counter width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage : mux_scan_seq_pkg

// File: rtl/mux_scan_seq_dwell_cnt.sv
// Dwell counter: clear/enable 4-bit counter with a terminal flag at DWELL-1.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (priority over en_i)
//   en_i       : increment
//   tc_o_c     : combinational terminal flag, high while count == DWELL-1
module mux_scan_seq_dwell_cnt
  import mux_scan_seq_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o_c = (cnt_q == CNT_W'(DWELL - 1));

endmodule : mux_scan_seq_dwell_cnt

// File: rtl/mux_scan_seq.sv
// Scan sequencer for a 16:1 bit mux: steps the select, waits DWELL settle
// cycles per channel, samples the mux output and assembles a 16-bit frame
// offered to a consumer through a valid/ack handshake.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : begin a frame (honoured only when idle)
//   cont       : continuous mode, checked at frame completion
//   mask       : 1 = skip channel; captured at frame start
//   x          : bit returned by the mux for the current select
//   s          : mux select (current channel)
//   busy       : high whenever not idle
//   data       : last completed frame, bit k = channel k
//   valid      : data holds an unacknowledged frame
//   ack        : consumer accepts data while valid is high
//   overrun    : sticky, a frame landed on unacknowledged data
module mux_scan_seq
  import mux_scan_seq_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   mask,
  input  logic             x,
  output logic [SEL_W-1:0] s,
  output logic             busy,
  output logic [NCH-1:0]   data,
  output logic             valid,
  input  logic             ack,
  output logic             overrun
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ch_q, ch_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [NCH-1:0]     shadow_q, shadow_d;
  logic               busy_q, busy_d;
  logic [NCH-1:0]     data_q, data_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;

  logic               dcnt_clr, dcnt_en, dcnt_tc;
  logic               ch_masked, ch_last;

  assign ch_masked = mask_q[ch_q];
  assign ch_last   = (ch_q == SEL_W'(NCH - 1));

  mux_scan_seq_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (dcnt_clr),
    .en_i   (dcnt_en),
    .tc_o_c (dcnt_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Masked channels skip dwell and sample, advancing in one cycle
        if (ch_masked) begin
          state_d = ch_last ? ST_DONE : ST_SETTLE;
        end else if (dcnt_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        state_d = ch_last ? ST_DONE : ST_SETTLE;
      end
      ST_DONE: begin
        state_d = cont ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    ch_d      = ch_q;
    mask_d    = mask_q;
    shadow_d  = shadow_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    busy_d    = (state_d != ST_IDLE);
    dcnt_en   = 1'b0;
    dcnt_clr  = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d   = mask;
          shadow_d = '0;
          ch_d     = '0;
        end
      end
      ST_SETTLE: begin
        if (ch_masked) begin
          shadow_d[ch_q] = 1'b0;
          if (!ch_last) ch_d = ch_q + SEL_W'(1);
        end else if (!dcnt_tc) begin
          dcnt_en  = 1'b1;
          dcnt_clr = 1'b0;
        end
      end
      ST_SAMPLE: begin
        shadow_d[ch_q] = x;
        if (!ch_last) ch_d = ch_q + SEL_W'(1);
      end
      ST_DONE: begin
        if (cont) begin
          mask_d   = mask;
          shadow_d = '0;
          ch_d     = '0;
        end
      end
      default: ;
    endcase

    // Frame publication has priority over ack; an ack on the same edge
    // consumes the old frame, so no overrun is flagged.
    if (state_q == ST_DONE) begin
      data_d  = shadow_q;
      valid_d = 1'b1;
      if (valid_q && !ack) overrun_d = 1'b1;
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q      <= '0;
      mask_q    <= '0;
      shadow_q  <= '0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      mask_q    <= mask_d;
      shadow_q  <= shadow_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Select only moves on entry to SETTLE, so it mirrors the channel register
  assign s       = ch_q;
  assign busy    = busy_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule : mux_scan_seq

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq with DWELL=2; the mux is modelled by
// indexing a pattern register with the DUT select.
module tb_mux_scan_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cont;
  logic [15:0] mask;
  logic        x;
  logic [3:0]  s;
  logic        busy;
  logic [15:0] data;
  logic        valid;
  logic        ack;
  logic        overrun;

  logic [15:0] pat;
  int          n_cmp;
  int          n_err;

  mux_scan_seq #(.DWELL(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cont    (cont),
    .mask    (mask),
    .x       (x),
    .s       (s),
    .busy    (busy),
    .data    (data),
    .valid   (valid),
    .ack     (ack),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb x = pat[s];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    ack   = 1'b0;
    mask  = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns just after the edge (E0) that samples start
  task automatic pulse_start(input logic [15:0] m);
    @(negedge clk);
    mask  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (valid !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; cont = 1'b0; ack = 1'b0; mask = 16'h0; pat = 16'h0;
    #1;
    n_cmp++; if (s !== 4'd0) begin n_err++; $display("FAIL reset_s: got %0d expected 0", s); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0000", data); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n;
    do_reset();
    pat = 16'hA5C3;
    pulse_start(16'h0000);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_run: got %b expected 1", busy); end
    wait_valid(n);
    n_cmp++; if (n !== 49) begin n_err++; $display("FAIL single_edges: got %0d expected 49", n); end
    n_cmp++; if (data !== 16'hA5C3) begin n_err++; $display("FAIL single_data: got %h expected a5c3", data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b expected 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL single_overrun: got %b expected 0", overrun); end
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_ack_clear: got %b expected 0", valid); end
    // ack while nothing is pending must be harmless
    @(posedge clk); #1;
    ack = 1'b0;
    n_cmp++; if (valid !== 1'b0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL single_idle_ack: got valid=%b overrun=%b expected 0/0", valid, overrun);
    end
    n_cmp++; if (data !== 16'hA5C3) begin n_err++; $display("FAIL single_data_hold: got %h expected a5c3", data); end
  endtask

  task automatic test_mask();
    int n;
    do_reset();
    pat = 16'hA5C3;
    pulse_start(16'h00FF);
    mask = 16'h0000;  // must not affect the running frame
    wait_valid(n);
    n_cmp++; if (n !== 33) begin n_err++; $display("FAIL mask_edges: got %0d expected 33", n); end
    n_cmp++; if (data !== 16'hA500) begin n_err++; $display("FAIL mask_data: got %h expected a500", data); end
  endtask

  task automatic test_all_masked();
    int n;
    do_reset();
    pat = 16'hFFFF;
    pulse_start(16'hFFFF);
    wait_valid(n);
    n_cmp++; if (n !== 17) begin n_err++; $display("FAIL allmask_edges: got %0d expected 17", n); end
    n_cmp++; if (data !== 16'h0000) begin n_err++; $display("FAIL allmask_data: got %h expected 0000", data); end
  endtask

  task automatic test_overrun();
    int n;
    do_reset();
    pat  = 16'hA5C3;
    cont = 1'b1;
    pulse_start(16'h0000);
    wait_valid(n);
    n_cmp++; if (n !== 49) begin n_err++; $display("FAIL ovr_edges1: got %0d expected 49", n); end
    n_cmp++; if (data !== 16'hA5C3) begin n_err++; $display("FAIL ovr_data1: got %h expected a5c3", data); end
    pat  = 16'h3C5A;
    cont = 1'b0;
    n = 0;
    while (overrun !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    n_cmp++; if (n !== 49) begin n_err++; $display("FAIL ovr_edges2: got %0d expected 49", n); end
    n_cmp++; if (data !== 16'h3C5A) begin n_err++; $display("FAIL ovr_data2: got %h expected 3c5a", data); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b expected 1", valid); end
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_ack_valid: got %b expected 0", valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky_late: got %b expected 1", overrun); end
  endtask

  task automatic test_ack_on_done();
    int n;
    do_reset();
    pat  = 16'hA5C3;
    cont = 1'b1;
    pulse_start(16'h0000);
    wait_valid(n);
    n_cmp++; if (n !== 49) begin n_err++; $display("FAIL ackdone_edges: got %0d expected 49", n); end
    pat  = 16'h1234;
    cont = 1'b0;
    repeat (48) @(posedge clk);
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ackdone_valid: got %b expected 1", valid); end
    n_cmp++; if (data !== 16'h1234) begin n_err++; $display("FAIL ackdone_data: got %h expected 1234", data); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ackdone_overrun: got %b expected 0", overrun); end
    @(posedge clk); #1;
    ack = 1'b0;
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ackdone_clear: got %b expected 0", valid); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    do_reset();
    pat = 16'hA5C3;
    pulse_start(16'h0000);
    repeat (23) @(posedge clk);
    #2;
    n_cmp++; if (s !== 4'd7 || busy !== 1'b1) begin
      n_err++; $display("FAIL midrst_pre: got s=%0d busy=%b expected 7/1", s, busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (s !== 4'd0) begin n_err++; $display("FAIL midrst_s: got %0d expected 0", s); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", valid); end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(16'h0000);
    wait_valid(n);
    n_cmp++; if (n !== 49) begin n_err++; $display("FAIL midrst_edges: got %0d expected 49", n); end
    n_cmp++; if (data !== 16'hA5C3) begin n_err++; $display("FAIL midrst_data: got %h expected a5c3", data); end
  endtask

  task automatic test_start_while_busy();
    int n;
    do_reset();
    pat = 16'hA5C3;
    pulse_start(16'h0000);
    n = 0;
    while (valid !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
      start = (n == 10 || n == 20);
      mask  = (n >= 10) ? 16'hFFFF : 16'h0000;
    end
    start = 1'b0;
    n_cmp++; if (n !== 49) begin n_err++; $display("FAIL busystart_edges: got %0d expected 49", n); end
    n_cmp++; if (data !== 16'hA5C3) begin n_err++; $display("FAIL busystart_data: got %h expected a5c3", data); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    ack   = 1'b0;
    mask  = 16'h0000;
    pat   = 16'h0000;
    test_reset();
    test_single();
    test_mask();
    test_all_masked();
    test_overrun();
    test_ack_on_done();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_scan_seq
